ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
- Receives keyboard frames on the PS/2 pins and decodes them into key events (make/break, extended) for the game logic.
- This is the input side of the board I/O, complementing the VGA output path.
- Sits between the top-level ps2_clk/ps2_data pins and the score/game state logic.
- The device drives the bus; this block only samples it and never drives the pins.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth applied to each of ps2_clk and ps2_data (minimum 2).
- TIMEOUT_CYCLES, 5000: clk cycles allowed between successive ps2_clk falling edges inside a frame. Used only when PS2_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; sole clock domain.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the pin (asynchronous).
- ps2_data  input  1  raw PS/2 data from the pin (asynchronous).
- key_valid  output  1  one-cycle pulse when a complete key event is available.
- key_code  output  8  scan code of the last event; held until the next event.
- key_break  output  1  1 if the last event was a release (preceded by F0).
- key_ext  output  1  1 if the last event was extended (preceded by E0).
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. Reset has priority over every other event. On reset: key_valid=0, key_code=8'h00, key_break=0, key_ext=0, frame_err=0, busy=0, state=IDLE, bit counter=0, brk_pending=0, ext_pending=0, synchronizers=1.
- Synchronization and edge detection:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - A falling edge (fe) is flagged when the previous synchronized ps2_clk is 1 and the current one is 0.
  - Data is sampled only in cycles where fe=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0 (start bit), go to DATA and clear the bit counter. On fe with data=1, stay in IDLE with no error.
  - DATA: on each fe, shift data in LSB first and increment the counter. After the 8th bit, go to PARITY.
  - PARITY: on fe, capture the parity bit, then go to STOP.
  - STOP: on fe, evaluate the frame, then go to IDLE.
- Frame evaluation (in the STOP fe cycle):
  - A frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity) AND the stop bit is 1.
  - Good, byte=E0: set ext_pending; no key_valid.
  - Good, byte=F0: set brk_pending; no key_valid.
  - Good, any other byte:
    - key_code <= byte, key_break <= brk_pending, key_ext <= ext_pending;
    - key_valid pulses high for exactly one cycle;
    - brk_pending and ext_pending are cleared.
  - Bad frame: frame_err pulses for one cycle; brk_pending and ext_pending are cleared; key outputs are unchanged.
- Latency: key_valid/frame_err are registered and assert on the clk edge at the end of the fe cycle for the stop bit. That is SYNC_STAGES+1 cycles after the raw ps2_clk falls.
- Input timing requirement: each ps2_clk high and low phase must last at least SYNC_STAGES+2 clk cycles. Shorter glitches are outside spec.
- key_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro name: PS2_TIMEOUT_EN.
- Defined:
  - A counter is cleared on every fe and whenever state=IDLE; it increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES in a non-IDLE state: frame_err pulses for one cycle, state returns to IDLE, and both pendings clear.
- Not defined:
  - No counter exists and TIMEOUT_CYCLES is unused.
  - A truncated frame keeps busy=1 until further edges arrive or reset is asserted.

Test Plan:
1. Frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> one key_valid pulse; key_code=0x1C, key_break=0, key_ext=0; busy returns to 0.
2. Frames F0 then 0x1C -> no key_valid after F0; after 0x1C, key_valid with key_code=0x1C, key_break=1, key_ext=0.
3. Frames E0, F0, 0x75 (parity 0) -> a single key_valid; key_code=0x75, key_break=1, key_ext=1. A following 0x1C reports break=0, ext=0.
4. F0 followed by 0x1C with parity 1 -> frame_err pulse and no key_valid. A subsequent good 0x1C reports key_break=0. key_code stays at its old value until then.
5. PS2_TIMEOUT_EN defined: start bit plus 3 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES cycles after the last fe, busy=0. A following 0x29 (parity 0) decodes correctly. With the macro undefined, busy stays 1.
6. reset asserted for 1 cycle after F0 and mid-way through the next frame -> all outputs are at reset values. A following clean 0x1C yields key_break=0, key_ext=0.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames and decodes E0/F0 prefixes into key events.
// Optional inter-edge timeout is enabled by defining PS2_TIMEOUT_EN.
`default_nettype none

module ps2_key_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fe, data_bit;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   parity_bit;
  logic                   brk_pending, ext_pending;
  logic                   frame_good, timeout_hit;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe         = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit   = data_sync[SYNC_STAGES-1];
  assign frame_good = (^{shift, parity_bit}) & data_bit;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || fe || state == IDLE) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th clock edge after the last falling edge.
  assign timeout_hit = (state != IDLE) && !fe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = IDLE;
    end else if (fe) begin
      case (state)
        IDLE:    if (!data_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      brk_pending <= 1'b0;
      ext_pending <= 1'b0;
      key_code    <= 8'h00;
      key_break   <= 1'b0;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; later assignments in this block win, so each lasts exactly one clock.
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_hit) begin
        frame_err   <= 1'b1;
        brk_pending <= 1'b0;
        ext_pending <= 1'b0;
      end else if (fe) begin
        case (state)
          IDLE: if (!data_bit) bit_cnt <= '0;
          DATA: begin
            shift   <= {data_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: parity_bit <= data_bit;
          STOP: begin
            if (frame_good) begin
              if (shift == 8'hE0) begin
                ext_pending <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_pending <= 1'b1;
              end else begin
                key_code    <= shift;
                key_break   <= brk_pending;
                key_ext     <= ext_pending;
                key_valid   <= 1'b1;
                brk_pending <= 1'b0;
                ext_pending <= 1'b0;
              end
            end else begin
              frame_err   <= 1'b1;
              brk_pending <= 1'b0;
              ext_pending <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios plus random frames against a scan-code level model.
`timescale 1ns/1ps

module tb_ps2_key_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid, key_break, key_ext, frame_err, busy;
  logic [7:0] key_code;

  ps2_key_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
    .key_ext(key_ext), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, fall_cyc = 0, valid_cyc = 0, err_cyc = 0;
  int n_valid = 0, n_err = 0, n_both = 0;

  // Scan-code level model of what the keyboard protocol should produce.
  int         exp_valid = 0, exp_err = 0;
  bit         m_brk = 0, m_ext = 0;
  logic [7:0] m_code = 8'h00;
  bit         m_break_o = 0, m_ext_o = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin n_valid++; valid_cyc = cyc; end
    if (frame_err) begin n_err++;   err_cyc   = cyc; end
    if (key_valid && frame_err) n_both++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_code = 8'h00; m_break_o = 0; m_ext_o = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err++; m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_valid++; m_code = b; m_break_o = m_brk; m_ext_o = m_ext;
      m_brk = 0; m_ext = 0;
    end
  endtask

  // Drives nbits of the 11-bit frame; data changes while ps2_clk is high.
  task automatic drive_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cycles($urandom_range(4, 9));
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cycles($urandom_range(4, 9));
      ps2_clk  = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    drive_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cycles(10);
    model_frame(b, bad_par | bad_stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_key_code got=%h exp=00", key_code); end
    checks++; if (key_break !== 1'b0) begin errors++; $display("FAIL reset_key_break got=%b exp=0", key_break); end
    checks++; if (key_ext !== 1'b0)   begin errors++; $display("FAIL reset_key_ext got=%b exp=0", key_ext); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_make();
    send_frame(8'h1C, 0, 0);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL make_valid_count got=%0d exp=%0d", n_valid, exp_valid); end
    checks++; if (key_code !== 8'h1C) begin errors++; $display("FAIL make_code got=%h exp=1c", key_code); end
    checks++; if (key_break !== 1'b0 || key_ext !== 1'b0) begin errors++; $display("FAIL make_flags got=%b%b exp=00", key_break, key_ext); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL make_busy got=%b exp=0", busy); end
    checks++; if (valid_cyc - fall_cyc !== SYNC + 1) begin errors++; $display("FAIL make_latency got=%0d exp=%0d", valid_cyc - fall_cyc, SYNC + 1); end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 0, 0);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL break_prefix_valid got=%0d exp=%0d", n_valid, exp_valid); end
    send_frame(8'h1C, 0, 0);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL break_valid_count got=%0d exp=%0d", n_valid, exp_valid); end
    checks++; if (key_code !== 8'h1C || key_break !== 1'b1 || key_ext !== 1'b0) begin
      errors++; $display("FAIL break_event got=%h/%b/%b exp=1c/1/0", key_code, key_break, key_ext); end
  endtask

  task automatic test_extended();
    int v0;
    v0 = n_valid;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ext_single_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (key_code !== 8'h75 || key_break !== 1'b1 || key_ext !== 1'b1) begin
      errors++; $display("FAIL ext_event got=%h/%b/%b exp=75/1/1", key_code, key_break, key_ext); end
    send_frame(8'h1C, 0, 0);
    checks++; if (key_code !== 8'h1C || key_break !== 1'b0 || key_ext !== 1'b0) begin
      errors++; $display("FAIL ext_cleared got=%h/%b/%b exp=1c/0/0", key_code, key_break, key_ext); end
  endtask

  task automatic test_frame_errors();
    send_frame(8'h5A, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    checks++; if (n_err !== exp_err) begin errors++; $display("FAIL parity_err_count got=%0d exp=%0d", n_err, exp_err); end
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL parity_no_valid got=%0d exp=%0d", n_valid, exp_valid); end
    checks++; if (key_code !== 8'h5A) begin errors++; $display("FAIL parity_code_held got=%h exp=5a", key_code); end
    checks++; if (err_cyc - fall_cyc !== SYNC + 1) begin errors++; $display("FAIL parity_err_latency got=%0d exp=%0d", err_cyc - fall_cyc, SYNC + 1); end
    send_frame(8'h1C, 0, 0);
    checks++; if (key_code !== 8'h1C || key_break !== 1'b0) begin
      errors++; $display("FAIL parity_recover got=%h/%b exp=1c/0", key_code, key_break); end
    send_frame(8'h33, 0, 1);
    checks++; if (n_err !== exp_err || n_valid !== exp_valid) begin
      errors++; $display("FAIL stop_err got=%0d/%0d exp=%0d/%0d", n_err, n_valid, exp_err, exp_valid); end
  endtask

  task automatic test_truncated();
    send_frame(8'hF0, 0, 0);
    drive_bits({2'b11, 8'b0000_0101, 1'b0}, 4);
`ifdef PS2_TIMEOUT_EN
    wait_cycles(TMO + 20);
    exp_err++; m_brk = 0; m_ext = 0;
    checks++; if (n_err !== exp_err) begin errors++; $display("FAIL timeout_err_count got=%0d exp=%0d", n_err, exp_err); end
    checks++; if (err_cyc - fall_cyc !== SYNC + 1 + TMO) begin
      errors++; $display("FAIL timeout_latency got=%0d exp=%0d", err_cyc - fall_cyc, SYNC + 1 + TMO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    send_frame(8'h29, 0, 0);
    checks++; if (key_code !== 8'h29 || key_break !== 1'b0 || key_ext !== 1'b0) begin
      errors++; $display("FAIL timeout_recover got=%h/%b/%b exp=29/0/0", key_code, key_break, key_ext); end
`else
    wait_cycles(TMO + 20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL truncated_busy got=%b exp=1", busy); end
    checks++; if (n_err !== exp_err) begin errors++; $display("FAIL truncated_no_err got=%0d exp=%0d", n_err, exp_err); end
    reset = 1'b1; wait_cycles(1); reset = 1'b0;
    model_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL truncated_reset_busy got=%b exp=0", busy); end
`endif
  endtask

  task automatic test_reset_mid();
    send_frame(8'h4B, 0, 0);
    send_frame(8'hF0, 0, 0);
    drive_bits({2'b11, 8'b1010_1010, 1'b0}, 5);
    reset = 1'b1; wait_cycles(1); reset = 1'b0;
    model_reset();
    checks++; if (key_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl got=%b%b%b exp=000", key_valid, frame_err, busy); end
    checks++; if (key_code !== 8'h00 || key_break !== 1'b0 || key_ext !== 1'b0) begin
      errors++; $display("FAIL midreset_key got=%h/%b/%b exp=00/0/0", key_code, key_break, key_ext); end
    wait_cycles(10);
    send_frame(8'h1C, 0, 0);
    checks++; if (key_code !== 8'h1C || key_break !== 1'b0 || key_ext !== 1'b0) begin
      errors++; $display("FAIL midreset_recover got=%h/%b/%b exp=1c/0/0", key_code, key_break, key_ext); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad_par, bad_stop;
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else            b = 8'($urandom_range(0, 255));
      bad_par  = ($urandom_range(0, 7) == 0);
      bad_stop = !bad_par && ($urandom_range(0, 9) == 0);
      send_frame(b, bad_par, bad_stop);
      checks++; if (n_valid !== exp_valid || n_err !== exp_err) begin
        errors++; $display("FAIL rand_counts[%0d] got=%0d/%0d exp=%0d/%0d", n, n_valid, n_err, exp_valid, exp_err); end
      checks++; if (key_code !== m_code || key_break !== m_break_o || key_ext !== m_ext_o) begin
        errors++; $display("FAIL rand_event[%0d] got=%h/%b/%b exp=%h/%b/%b", n, key_code, key_break, key_ext, m_code, m_break_o, m_ext_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d] got=%b exp=0", n, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_frame_errors();
    test_truncated();
    test_reset_mid();
    test_random();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap got=%0d exp=0", n_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
